// File: rtl/mario_motion.sv
// mario_motion: per-frame player motion controller feeding the colour mapper.
// Turns the current keycode into the sprite top-left position (MarioX, MarioY)
// and facing direction once per video frame. Frames are detected from the
// rising edge of the VGA vsync (frame_clk), which is asynchronous to Clk.
// Handles walking, jumping, gravity, ground landing and screen clamping.
//
// Optional build macro: WALK_ANIM_EN
//   defined   -> a 3-bit tick divider drives a 0,1,2 walk animation index
//   undefined -> walk_frame is tied to 0

module mario_motion #(
    parameter int          X_START   = 100,
    parameter int          GROUND_Y  = 400,
    parameter int          SIZE      = 16,
    parameter int          SCREEN_W  = 640,
    parameter int          X_STEP    = 2,
    parameter int          JUMP_V    = 12,
    parameter int          GRAVITY   = 1,
    parameter logic [7:0]  KEY_RIGHT = 8'h07,
    parameter logic [7:0]  KEY_LEFT  = 8'h04,
    parameter logic [7:0]  KEY_JUMP  = 8'h1A
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    output logic [9:0]  MarioX,
    output logic [9:0]  MarioY,
    output logic        facing_left,
    output logic        airborne,
    output logic [1:0]  walk_frame
);

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } state_t;

    // Constants in the 12-bit signed domain used for all position math, so
    // subtraction below zero is visible as a negative value, never a wrap.
    localparam logic signed [11:0] C_GROUND    = 12'(GROUND_Y);
    localparam logic signed [11:0] C_X_MAX     = 12'(SCREEN_W - SIZE);
    localparam logic signed [11:0] C_X_STEP    = 12'(X_STEP);
    localparam logic signed [7:0]  C_GRAVITY   = 8'(GRAVITY);
    localparam logic signed [7:0]  C_VY_LAUNCH = 8'(-JUMP_V);
    localparam logic [9:0]         C_X_RESET   = 10'(X_START);
    localparam logic [9:0]         C_Y_GROUND  = 10'(GROUND_Y);
    localparam logic [9:0]         C_X_MAX_U   = 10'(SCREEN_W - SIZE);

    // frame boundary detection
    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic w_tick;

    // motion state
    state_t             r_state;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic signed [7:0]  r_vy;
    logic               r_facing;
    logic               r_air;

    // next-state values
    state_t             w_state_nxt;
    logic [9:0]         w_x_nxt;
    logic [9:0]         w_y_nxt;
    logic signed [7:0]  w_vy_nxt;
    logic               w_facing_nxt;

    // arithmetic helpers
    logic signed [11:0] w_x_s;
    logic signed [11:0] w_x_add;
    logic signed [11:0] w_x_sub;
    logic signed [11:0] w_y_s;
    logic signed [11:0] w_vy_s;
    logic signed [11:0] w_ny;
    logic signed [7:0]  w_nv;
    logic               w_key_walk;

    assign w_tick     = r_sync2 & ~r_hist;
    assign w_key_walk = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT);

    assign w_x_s   = $signed({2'b00, r_x});
    assign w_x_add = w_x_s + C_X_STEP;
    assign w_x_sub = w_x_s - C_X_STEP;
    assign w_y_s   = $signed({2'b00, r_y});
    assign w_vy_s  = $signed({{4{r_vy[7]}}, r_vy});
    assign w_ny    = w_y_s + w_vy_s;
    assign w_nv    = r_vy + C_GRAVITY;

    // Two-flop synchroniser for vsync plus a history flop for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Next-state: horizontal walk with clamping, then the jump/gravity FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_vy_nxt     = r_vy;
        w_facing_nxt = r_facing;

        if (keycode == KEY_RIGHT) begin
            w_x_nxt      = (w_x_add > C_X_MAX) ? C_X_MAX_U : w_x_add[9:0];
            w_facing_nxt = 1'b0;
        end else if (keycode == KEY_LEFT) begin
            w_x_nxt      = (w_x_sub < 12'sd0) ? 10'd0 : w_x_sub[9:0];
            w_facing_nxt = 1'b1;
        end

        case (r_state)
            GROUND: begin
                // Y stays on the ground on the launch tick as well
                w_y_nxt  = C_Y_GROUND;
                w_vy_nxt = 8'sd0;
                if (keycode == KEY_JUMP) begin
                    w_vy_nxt    = C_VY_LAUNCH;
                    w_state_nxt = RISING;
                end
            end
            RISING, FALLING: begin
                // jump key is deliberately ignored while airborne
                if (w_ny >= C_GROUND) begin
                    w_y_nxt     = C_Y_GROUND;
                    w_vy_nxt    = 8'sd0;
                    w_state_nxt = GROUND;
                end else if (w_ny < 12'sd0) begin
                    // hit the ceiling: kill upward speed and start falling
                    w_y_nxt     = 10'd0;
                    w_vy_nxt    = 8'sd0;
                    w_state_nxt = FALLING;
                end else begin
                    w_y_nxt     = w_ny[9:0];
                    w_vy_nxt    = w_nv;
                    w_state_nxt = w_nv[7] ? RISING : FALLING;
                end
            end
            default: begin
                w_y_nxt     = C_Y_GROUND;
                w_vy_nxt    = 8'sd0;
                w_state_nxt = GROUND;
            end
        endcase
    end

    // State register: everything advances only on the frame tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= GROUND;
            r_x      <= C_X_RESET;
            r_y      <= C_Y_GROUND;
            r_vy     <= 8'sd0;
            r_facing <= 1'b0;
            r_air    <= 1'b0;
        end else if (w_tick) begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_vy     <= w_vy_nxt;
            r_facing <= w_facing_nxt;
            r_air    <= (w_state_nxt != GROUND);
        end
    end

`ifdef WALK_ANIM_EN
    logic [2:0] r_div;
    logic [1:0] r_walk;

    // Walk animation: advance 0,1,2 every 8 ticks while walking on the ground.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_div  <= 3'd0;
            r_walk <= 2'd0;
        end else if (w_tick) begin
            if ((r_state == GROUND) && w_key_walk) begin
                r_div <= r_div + 3'd1;
                if (r_div == 3'd7) begin
                    r_walk <= (r_walk == 2'd2) ? 2'd0 : (r_walk + 2'd1);
                end
            end else begin
                r_div  <= 3'd0;
                r_walk <= 2'd0;
            end
        end
    end

    assign walk_frame = r_walk;
`else
    logic w_unused_walk;
    assign w_unused_walk = w_key_walk;
    assign walk_frame    = 2'b00;
`endif

    assign MarioX      = r_x;
    assign MarioY      = r_y;
    assign facing_left = r_facing;
    assign airborne    = r_air;

endmodule

// File: tb/tb_mario_motion.sv
// Testbench for mario_motion: table-driven vectors plus a reference model
// feeding an expected-value queue, and hand-written multi-tick sequences.
module tb_mario_motion;

    localparam logic [7:0] KR = 8'h07;
    localparam logic [7:0] KL = 8'h04;
    localparam logic [7:0] KJ = 8'h1A;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic [7:0]  keycode2;
    logic [9:0]  mx, my, mx2, my2;
    logic        mf, ma, mf2, ma2;
    logic [1:0]  mw, mw2;

    always #5 clk = ~clk;

    mario_motion dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(keycode),
        .MarioX(mx), .MarioY(my), .facing_left(mf), .airborne(ma), .walk_frame(mw)
    );

    mario_motion #(.JUMP_V(40)) dut2 (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(keycode2),
        .MarioX(mx2), .MarioY(my2), .facing_left(mf2), .airborne(ma2), .walk_frame(mw2)
    );

    typedef struct { int x; int y; int f; int a; int w; } exp_t;
    typedef struct { logic [7:0] key; int x; int y; int f; int a; } vec_t;

    exp_t exp_q[$];
    exp_t last_e;
    vec_t tab[12];

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_x, m_y, m_vy, m_f, m_a, m_div, m_w;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_x = 100; m_y = 400; m_vy = 0; m_f = 0; m_a = 0; m_div = 0; m_w = 0;
    endtask

    task automatic model_step(input logic [7:0] key);
        int ny, nv;
`ifdef WALK_ANIM_EN
        if (m_a == 0 && (key == KL || key == KR)) begin
            m_div = (m_div + 1) % 8;
            if (m_div == 0) m_w = (m_w + 1) % 3;
        end else begin
            m_div = 0;
            m_w = 0;
        end
`endif
        if (key == KR) begin
            m_x = (m_x + 2 > 624) ? 624 : m_x + 2;
            m_f = 0;
        end else if (key == KL) begin
            m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
            m_f = 1;
        end
        if (m_a == 0) begin
            if (key == KJ) begin
                m_vy = -12;
                m_a = 1;
            end
        end else begin
            ny = m_y + m_vy;
            nv = m_vy + 1;
            if (ny >= 400) begin
                m_y = 400; m_vy = 0; m_a = 0;
            end else if (ny < 0) begin
                m_y = 0; m_vy = 0;
            end else begin
                m_y = ny; m_vy = nv;
            end
        end
    endtask

    // One frame: push the expectation, raise vsync, check the outputs hold
    // until the update edge, then pop and compare after it.
    task automatic run_tick(input logic [7:0] key, input exp_t e_in);
        exp_t e;
        keycode = key;
        exp_q.push_back(e_in);
        @(negedge clk);
        frame_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("hold_x", int'(mx), last_e.x);
        check("hold_y", int'(my), last_e.y);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL queue_empty: got 0 entries, expected 1");
        end else begin
            e = exp_q.pop_front();
            check("x", int'(mx), e.x);
            check("y", int'(my), e.y);
            check("facing", int'(mf), e.f);
            check("airborne", int'(ma), e.a);
            check("walk", int'(mw), e.w);
            last_e = e;
        end
        frame_clk = 1'b0;
        // keycode changing between ticks must have no effect
        keycode = 8'($urandom_range(0, 255));
        repeat (3) @(negedge clk);
    endtask

    task automatic tick_model(input logic [7:0] key);
        exp_t e;
        model_step(key);
        e = '{m_x, m_y, m_f, m_a, m_w};
        run_tick(key, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_x", int'(mx), 100);
        check("rst_y", int'(my), 400);
        check("rst_facing", int'(mf), 0);
        check("rst_airborne", int'(ma), 0);
        check("rst_walk", int'(mw), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        last_e = '{100, 400, 0, 0, 0};
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        tab[0]  = '{8'h00, 100, 400, 0, 0};
        tab[1]  = '{8'h00, 100, 400, 0, 0};
        tab[2]  = '{8'h00, 100, 400, 0, 0};
        tab[3]  = '{KR,    102, 400, 0, 0};
        tab[4]  = '{KR,    104, 400, 0, 0};
        tab[5]  = '{KL,    102, 400, 1, 0};
        tab[6]  = '{8'h55, 102, 400, 1, 0};
        tab[7]  = '{KJ,    102, 400, 1, 1};
        tab[8]  = '{8'h00, 102, 388, 1, 1};
        tab[9]  = '{KR,    104, 377, 0, 1};
        tab[10] = '{KJ,    104, 367, 0, 1};
        tab[11] = '{KL,    102, 358, 1, 1};

        rst = 1'b1;
        frame_clk = 1'b0;
        keycode = 8'h00;
        keycode2 = 8'h00;
        repeat (3) @(negedge clk);
        check("init_x", int'(mx), 100);
        check("init_y", int'(my), 400);
        check("init_airborne", int'(ma), 0);
        rst = 1'b0;
        last_e = '{100, 400, 0, 0, 0};
        model_reset();
        repeat (2) @(negedge clk);

        // table-driven vectors from reset
        for (int i = 0; i < 12; i++) begin
            e = '{tab[i].x, tab[i].y, tab[i].f, tab[i].a, 0};
            run_tick(tab[i].key, e);
        end

        // reset while airborne
        check("pre_reset_airborne", int'(ma), 1);
        do_reset();

        // walk right to the right edge, then one step left
        for (int i = 1; i <= 300; i++) begin
            tick_model(KR);
            if (i == 261) check("x_t261", int'(mx), 622);
            if (i == 262) check("x_t262", int'(mx), 624);
            if (i == 300) check("x_t300", int'(mx), 624);
`ifdef WALK_ANIM_EN
            if (i == 7)  check("walk_t7", int'(mw), 0);
            if (i == 8)  check("walk_t8", int'(mw), 1);
            if (i == 16) check("walk_t16", int'(mw), 2);
            if (i == 24) check("walk_t24", int'(mw), 0);
`endif
        end
        tick_model(KL);
        check("x_left_from_edge", int'(mx), 622);
        check("facing_left_from_edge", int'(mf), 1);

        // walk left to the left edge; no wrap
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            tick_model(KL);
            if (i == 50) check("x_t50", int'(mx), 0);
            if (i == 60) check("x_t60", int'(mx), 0);
        end
        tick_model(8'h00);
        tick_model(KJ);
        check("launch_airborne", int'(ma), 1);
        check("launch_y", int'(my), 400);
        for (int i = 1; i <= 25; i++) begin
            tick_model(8'h00);
            if (i == 1)  check("jump_y_t1", int'(my), 388);
            if (i == 11) check("jump_y_t11", int'(my), 323);
            if (i == 12) check("jump_y_t12", int'(my), 322);
            if (i == 13) check("jump_y_t13", int'(my), 322);
            if (i == 14) check("jump_y_t14", int'(my), 323);
            if (i == 24) check("jump_air_t24", int'(ma), 1);
            if (i == 25) check("land_y_t25", int'(my), 400);
            if (i == 25) check("land_air_t25", int'(ma), 0);
        end

        // high jump on the JUMP_V=40 instance hits the ceiling
        keycode2 = KJ;
        tick_model(8'h00);
        check("hi_launch_air", int'(ma2), 1);
        check("hi_launch_y", int'(my2), 400);
        keycode2 = 8'h00;
        for (int i = 1; i <= 41; i++) begin
            tick_model(8'h00);
            if (i == 1)  check("hi_y_t1", int'(my2), 360);
            if (i == 11) check("hi_y_t11", int'(my2), 15);
            if (i == 12) check("hi_y_t12", int'(my2), 0);
            if (i == 12) check("hi_air_t12", int'(ma2), 1);
            if (i == 13) check("hi_y_t13", int'(my2), 0);
            if (i == 14) check("hi_y_t14", int'(my2), 1);
            if (i == 40) check("hi_y_t40", int'(my2), 378);
            if (i == 41) check("hi_y_t41", int'(my2), 400);
            if (i == 41) check("hi_air_t41", int'(ma2), 0);
        end

        // jump held continuously: land, then relaunch on the next tick
        do_reset();
        for (int i = 0; i <= 27; i++) begin
            tick_model(KJ);
            if (i == 0)  check("hold_launch_air", int'(ma), 1);
            if (i == 12) check("hold_y_t12", int'(my), 322);
            if (i == 25) check("hold_land_y", int'(my), 400);
            if (i == 25) check("hold_land_air", int'(ma), 0);
            if (i == 26) check("relaunch_air", int'(ma), 1);
            if (i == 26) check("relaunch_y", int'(my), 400);
            if (i == 27) check("relaunch_y_t1", int'(my), 388);
        end
        check("rising_air_before_reset", int'(ma), 1);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
